// File: rtl/oc_thermal_throttle_pkg.sv
// Shared types for the thermal throttle block: FSM state encoding and CSR identity.
package oclib_pkg;

  typedef enum logic [1:0] {
    ThrottleNormal   = 2'd0,
    ThrottleThrottle = 2'd1,
    ThrottleShutdown = 2'd2
  } throttle_state_e;

  localparam logic [15:0] CsrIdThermalThrottle = 16'h0071;

  // Clock cycles per microsecond, never below one.
  function automatic int cyclesPerUs(input longint clockHz);
    longint div;
    div = clockHz / 64'd1_000_000;
    return (div < 64'd1) ? 1 : int'(div);
  endfunction

endpackage

// File: rtl/oc_thermal_throttle_if.sv
// Alarm inputs and throttle outputs bundled between the chip monitor side and the user core.
interface oc_thermal_throttle_if #(
  parameter int PwmBits = 8
);
  import oclib_pkg::*;

  logic             enable;
  logic             thermalWarning;
  logic             thermalError;
  logic             allow;
  logic [PwmBits:0] duty;
  throttle_state_e  state;
  logic             shutdownRequest;
  logic [15:0]      throttleEvents;

  modport master (
    output enable, thermalWarning, thermalError,
    input  allow, duty, state, shutdownRequest, throttleEvents
  );

  modport slave (
    input  enable, thermalWarning, thermalError,
    output allow, duty, state, shutdownRequest, throttleEvents
  );

endinterface

// File: rtl/oc_thermal_throttle_debounce.sv
// Reusable alarm conditioning: a flop-chain synchronizer followed by a stable-for-N-ticks filter.
module oclib_synchronizer #(
  parameter int Stages = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [Stages-1:0] syncQ;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      syncQ <= '0;
    end else begin
      syncQ[0] <= d;
      for (int i = 1; i < Stages; i++) syncQ[i] <= syncQ[i-1];
    end
  end

  assign q = syncQ[Stages-1];
endmodule

module oclib_debounce #(
  parameter int SyncCycles = 3,
  parameter int DebounceUs = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic deb
);
  localparam int CntW = $clog2(DebounceUs + 1);

  logic            synced;
  logic [CntW-1:0] cnt;

  oclib_synchronizer #(.Stages(SyncCycles)) uSync (
    .clock (clock),
    .reset (reset),
    .d     (raw),
    .q     (synced)
  );

  // Any tick-window where the synced input matches the output restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (synced == deb) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CntW'(DebounceUs - 1)) begin
        deb <= synced;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/oc_thermal_throttle.sv
// Turns debounced thermal alarms into a PWM activity gate with ramped duty and an error shutdown.
module oc_thermal_throttle
  import oclib_pkg::*;
#(
  parameter longint ClockHz    = 100_000_000,
  parameter int     SyncCycles = 3,
  parameter int     DebounceUs = 10,
  parameter int     RampStepUs = 1000,
  parameter int     PwmBits    = 8,
  parameter int     StepDown   = 32,
  parameter int     StepUp     = 8,
  parameter int     MinDuty    = 32,
  parameter int     CooldownUs = 100_000
) (
  input logic               clock,
  input logic               reset,
  oc_thermal_throttle_if.slave tif
);
  localparam int TickDiv = cyclesPerUs(ClockHz);
  localparam int PreW    = $clog2(TickDiv + 1);
  localparam int RampW   = $clog2(RampStepUs + 1);
  localparam int CoolW   = $clog2(CooldownUs + 1);
  localparam int DutyW   = PwmBits + 1;
  localparam int WideW   = PwmBits + 2;

  localparam logic [DutyW-1:0] FullDuty = DutyW'(2 ** PwmBits);
  localparam logic [DutyW-1:0] MinD     = DutyW'(MinDuty);

  localparam logic [1:0] StNormal   = 2'd0;
  localparam logic [1:0] StThrottle = 2'd1;
  localparam logic [1:0] StShutdown = 2'd2;

  logic [PreW-1:0]    preCnt;
  logic               tick;
  logic               warnD, errD;
  logic [1:0]         stateQ;
  logic [DutyW-1:0]   dutyQ;
  logic [RampW-1:0]   rampQ;
  logic [CoolW-1:0]   coolQ;
  logic [15:0]        throttleEventsQ;
  logic [PwmBits-1:0] pwmCnt;
  logic               allowQ;
  logic [WideW-1:0]   dutyWide, dutyDn, dutyUp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      preCnt <= '0;
      tick   <= 1'b0;
    end else if (preCnt == PreW'(TickDiv - 1)) begin
      preCnt <= '0;
      tick   <= 1'b1;
    end else begin
      preCnt <= preCnt + 1'b1;
      tick   <= 1'b0;
    end
  end

  oclib_debounce #(.SyncCycles(SyncCycles), .DebounceUs(DebounceUs)) uWarnDeb (
    .clock (clock), .reset (reset), .tick (tick), .raw (tif.thermalWarning), .deb (warnD)
  );

  oclib_debounce #(.SyncCycles(SyncCycles), .DebounceUs(DebounceUs)) uErrDeb (
    .clock (clock), .reset (reset), .tick (tick), .raw (tif.thermalError), .deb (errD)
  );

  // Step arithmetic is done one bit wider than duty and clamped, so it can never wrap.
  always_comb begin
    dutyWide = {1'b0, dutyQ};
    dutyDn   = (dutyWide >= WideW'(StepDown + MinDuty)) ? dutyWide - WideW'(StepDown)
                                                        : WideW'(MinDuty);
    dutyUp   = dutyWide + WideW'(StepUp);
    if (dutyUp > {1'b0, FullDuty}) dutyUp = {1'b0, FullDuty};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ          <= StNormal;
      dutyQ           <= FullDuty;
      rampQ           <= '0;
      coolQ           <= '0;
      throttleEventsQ <= '0;
    end else begin
      case (stateQ)
        StNormal: begin
          dutyQ <= FullDuty;
          if (errD) begin
            stateQ <= StShutdown;
            dutyQ  <= '0;
            coolQ  <= '0;
          end else if (warnD && tif.enable) begin
            stateQ <= StThrottle;
            rampQ  <= '0;
            if (throttleEventsQ != 16'hffff) throttleEventsQ <= throttleEventsQ + 1'b1;
          end
        end
        StThrottle: begin
          if (errD) begin
            stateQ <= StShutdown;
            dutyQ  <= '0;
            coolQ  <= '0;
          end else if (!tif.enable) begin
            stateQ <= StNormal;
            dutyQ  <= FullDuty;
          end else if (tick) begin
            if (rampQ == RampW'(RampStepUs - 1)) begin
              rampQ <= '0;
              if (warnD) begin
                dutyQ <= dutyDn[DutyW-1:0];
              end else begin
                dutyQ <= dutyUp[DutyW-1:0];
                if (dutyUp[DutyW-1:0] == FullDuty) stateQ <= StNormal;
              end
            end else begin
              rampQ <= rampQ + 1'b1;
            end
          end
        end
        default: begin
          dutyQ <= '0;
          if (errD) begin
            coolQ <= '0;
          end else if (tick) begin
            if (coolQ == CoolW'(CooldownUs - 1)) begin
              stateQ <= StThrottle;
              dutyQ  <= MinD;
              rampQ  <= '0;
              coolQ  <= '0;
            end else begin
              coolQ <= coolQ + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwmCnt <= '0;
      allowQ <= 1'b0;
    end else begin
      pwmCnt <= pwmCnt + 1'b1;
      allowQ <= ({1'b0, pwmCnt} < dutyQ);
    end
  end

  assign tif.allow           = allowQ;
  assign tif.duty            = dutyQ;
  assign tif.state           = throttle_state_e'(stateQ);
  assign tif.shutdownRequest = (stateQ == StShutdown);
  assign tif.throttleEvents  = throttleEventsQ;

endmodule

// File: tb/tb_oc_thermal_throttle.sv
// Directed bench: 1us = 10 cycles, debounce 2us, ramp step 10us, cooldown 50us.
module tb_oc_thermal_throttle;
  import oclib_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   nChecks = 0;
  int   nErrors = 0;
  int   allowCnt;

  oc_thermal_throttle_if #(.PwmBits(8)) tif ();

  oc_thermal_throttle #(
    .ClockHz(10_000_000), .SyncCycles(3), .DebounceUs(2), .RampStepUs(10), .PwmBits(8),
    .StepDown(32), .StepUp(8), .MinDuty(32), .CooldownUs(50)
  ) dut (
    .clock (clock),
    .reset (reset),
    .tif   (tif)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic waitState(input string tag, input throttle_state_e st, input int bound);
    for (int i = 0; i < bound && tif.state != st; i++) @(negedge clock);
    chk(tag, 32'(tif.state), 32'(st));
  endtask

  task automatic waitDutyNot(input string tag, input logic [8:0] d, input int bound);
    for (int i = 0; i < bound && tif.duty == d; i++) @(negedge clock);
    chk(tag, 32'(tif.duty != d), 32'd1);
  endtask

  initial begin
    tif.enable = 1'b1;
    tif.thermalWarning = 1'b0;
    tif.thermalError = 1'b0;

    // 1: reset state and release
    cyc(3);
    chk("rst_allow", 32'(tif.allow), 32'd0);
    chk("rst_duty", 32'(tif.duty), 32'd256);
    reset = 1'b1;
    cyc(3);
    chk("nrm_state", 32'(tif.state), 32'(ThrottleNormal));
    chk("nrm_duty", 32'(tif.duty), 32'd256);
    chk("nrm_allow", 32'(tif.allow), 32'd1);
    chk("nrm_events", 32'(tif.throttleEvents), 32'd0);
    chk("nrm_shut", 32'(tif.shutdownRequest), 32'd0);

    // 2: warning held, ramp down to floor
    tif.thermalWarning = 1'b1;
    waitState("thr_enter", ThrottleThrottle, 200);
    chk("thr_events", 32'(tif.throttleEvents), 32'd1);
    chk("thr_duty_full", 32'(tif.duty), 32'd256);
    cyc(50);
    chk("thr_duty_hold", 32'(tif.duty), 32'd256);
    waitDutyNot("thr_step1_time", 9'd256, 100);
    chk("thr_step1", 32'(tif.duty), 32'd224);
    cyc(1000);
    chk("thr_floor", 32'(tif.duty), 32'd32);
    allowCnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      if (tif.allow) allowCnt++;
    end
    chk("thr_pwm32", 32'(allowCnt), 32'd32);

    // 3: warning cleared, ramp back up to NORMAL
    tif.thermalWarning = 1'b0;
    waitDutyNot("rec_step1_time", 9'd32, 200);
    chk("rec_step1", 32'(tif.duty), 32'd40);
    waitState("rec_normal", ThrottleNormal, 3000);
    chk("rec_duty", 32'(tif.duty), 32'd256);
    chk("rec_events", 32'(tif.throttleEvents), 32'd1);

    // 4: 1us glitch is filtered
    tif.thermalWarning = 1'b1;
    cyc(10);
    tif.thermalWarning = 1'b0;
    cyc(100);
    chk("glitch_state", 32'(tif.state), 32'(ThrottleNormal));
    chk("glitch_events", 32'(tif.throttleEvents), 32'd1);

    // 5: error during THROTTLE, cooldown restart on re-pulse
    tif.thermalWarning = 1'b1;
    waitState("err_pre_thr", ThrottleThrottle, 200);
    tif.thermalError = 1'b1;
    waitState("err_shut", ThrottleShutdown, 100);
    chk("err_duty", 32'(tif.duty), 32'd0);
    chk("err_req", 32'(tif.shutdownRequest), 32'd1);
    tif.thermalWarning = 1'b0;
    cyc(2);
    chk("err_allow", 32'(tif.allow), 32'd0);
    tif.thermalError = 1'b0;
    cyc(300);
    chk("cool_mid", 32'(tif.state), 32'(ThrottleShutdown));
    tif.thermalError = 1'b1;
    cyc(50);
    tif.thermalError = 1'b0;
    cyc(400);
    chk("cool_restart", 32'(tif.state), 32'(ThrottleShutdown));
    waitState("cool_exit", ThrottleThrottle, 300);
    chk("cool_duty", 32'(tif.duty), 32'd32);
    chk("cool_events", 32'(tif.throttleEvents), 32'd2);
    chk("cool_req", 32'(tif.shutdownRequest), 32'd0);

    // 6: enable gating, async reset, event saturation
    tif.enable = 1'b0;
    cyc(3);
    chk("dis_state", 32'(tif.state), 32'(ThrottleNormal));
    chk("dis_duty", 32'(tif.duty), 32'd256);
    tif.thermalWarning = 1'b1;
    cyc(200);
    chk("dis_warn_state", 32'(tif.state), 32'(ThrottleNormal));
    tif.enable = 1'b1;
    waitState("en_thr", ThrottleThrottle, 20);
    chk("en_events", 32'(tif.throttleEvents), 32'd3);
    cyc(20);
    reset = 1'b0;
    #1;
    chk("arst_state", 32'(tif.state), 32'(ThrottleNormal));
    chk("arst_duty", 32'(tif.duty), 32'd256);
    chk("arst_allow", 32'(tif.allow), 32'd0);
    chk("arst_events", 32'(tif.throttleEvents), 32'd0);
    cyc(3);
    reset = 1'b1;
    waitState("arst_rethr", ThrottleThrottle, 200);
    chk("arst_events1", 32'(tif.throttleEvents), 32'd1);
    tif.enable = 1'b0;
    cyc(2);
    force dut.throttleEventsQ = 16'hfffe;
    cyc(1);
    release dut.throttleEventsQ;
    tif.enable = 1'b1;
    cyc(2);
    chk("sat_ffff", 32'(tif.throttleEvents), 32'h0000ffff);
    tif.enable = 1'b0;
    cyc(2);
    tif.enable = 1'b1;
    cyc(2);
    chk("sat_hold", 32'(tif.throttleEvents), 32'h0000ffff);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
